// File: rtl/sram_pkg.sv
// Shared request/response types and constants for the banked OBI SRAM subsystem.
package sram_pkg;

  localparam int SRAM_WORD_BYTES = 4;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

endpackage

// File: rtl/sram_1rw1r_32.sv
// Behavioural stand-in for a sky130 1rw1r 32-bit macro: active-low selects, byte write mask, registered reads.
module sram_1rw1r_32 #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              csb0,
  input  logic              web0,
  input  logic [3:0]        wmask0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       din0,
  output logic [31:0]       dout0,
  input  logic              csb1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [31:0]       dout1
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        dout0 <= mem[addr0];
      end
    end
    if (!csb1) dout1 <= mem[addr1];
  end

endmodule

// File: rtl/sram_addr_decode.sv
// Combinational address decode for one OBI port: byte address -> {hit, bank, word}.
module sram_addr_decode
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          NUM_BANKS      = 3,
  parameter int          LOG_BANK_WORDS = 9,
  parameter int          BANK_SEL_W     = 2
) (
  input  logic [31:0]               addr,
  output logic                      hit,
  output logic [BANK_SEL_W-1:0]     bank,
  output logic [LOG_BANK_WORDS-1:0] word
);

  // One extra bit so the exclusive end cannot wrap at the top of the address map.
  localparam logic [32:0] END_ADDR =
    {1'b0, BASE_ADDR} + 33'(NUM_BANKS * (SRAM_WORD_BYTES << LOG_BANK_WORDS));

  always_comb begin
    hit  = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < END_ADDR);
    bank = addr[LOG_BANK_WORDS+2 +: BANK_SEL_W];
    word = addr[LOG_BANK_WORDS+1:2];
  end

endmodule

// File: rtl/sram_banked_obi.sv
// Banked SRAM behind a read/write D port and a read-only I port, with range errors and collision handling.
// Optional feature macro SRAM_WR_FWD_EN: full-word D-write/I-read collisions forward the write data instead of stalling I.
module sram_banked_obi
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          NUM_BANKS      = 3,
  parameter int          LOG_BANK_WORDS = 9,
  parameter int          BANK_SEL_W     = $clog2(NUM_BANKS > 1 ? NUM_BANKS : 2)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_req_i,
  output logic        d_gnt_o,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  input  logic        i_req_i,
  output logic        i_gnt_o,
  input  logic [31:0] i_addr_i,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  output logic        illegal_memory_o
);

  obi_req_t d_req;
  obi_rsp_t d_rsp, i_rsp;

  logic                      d_hit, i_hit;
  logic [BANK_SEL_W-1:0]     d_bank, i_bank;
  logic [LOG_BANK_WORDS-1:0] d_word, i_word;

  logic collision, fwd_ok, i_stall, d_gnt, i_gnt;

  logic                  d_rvalid_q, d_err_q, d_rd_q;
  logic [BANK_SEL_W-1:0] d_bank_q;
  logic                  i_rvalid_q, i_err_q, i_rd_q, i_fwd_q;
  logic [BANK_SEL_W-1:0] i_bank_q;
  logic [31:0]           fwd_data_q;

  logic [31:0] d_dout [NUM_BANKS];
  logic [31:0] i_dout [NUM_BANKS];
  logic [31:0] d_rdata, i_rdata;

  assign d_req = {d_req_i, d_addr_i, d_we_i, d_be_i, d_wdata_i};

  sram_addr_decode #(
    .BASE_ADDR(BASE_ADDR), .NUM_BANKS(NUM_BANKS),
    .LOG_BANK_WORDS(LOG_BANK_WORDS), .BANK_SEL_W(BANK_SEL_W)
  ) u_d_decode (.addr(d_req.addr), .hit(d_hit), .bank(d_bank), .word(d_word));

  sram_addr_decode #(
    .BASE_ADDR(BASE_ADDR), .NUM_BANKS(NUM_BANKS),
    .LOG_BANK_WORDS(LOG_BANK_WORDS), .BANK_SEL_W(BANK_SEL_W)
  ) u_i_decode (.addr(i_addr_i), .hit(i_hit), .bank(i_bank), .word(i_word));

  // Port 1 reading the word port 0 is writing in the same cycle returns undefined data, so I must not read it.
  always_comb begin
    collision = d_req.req && d_req.we && d_hit && i_req_i && i_hit &&
                (d_bank == i_bank) && (d_word == i_word);
`ifdef SRAM_WR_FWD_EN
    fwd_ok    = collision && (d_req.be == 4'hF);
`else
    fwd_ok    = 1'b0;
`endif
    i_stall   = collision && !fwd_ok;
    d_gnt     = d_req.req && !rst_i;
    i_gnt     = i_req_i && !rst_i && !i_stall;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic d_sel, i_sel;
    assign d_sel = d_gnt && d_hit && (d_bank == BANK_SEL_W'(b));
    assign i_sel = i_gnt && i_hit && !fwd_ok && (i_bank == BANK_SEL_W'(b));

    sram_1rw1r_32 #(.ADDR_W(LOG_BANK_WORDS)) u_macro (
      .clk   (clk_i),
      .csb0  (!d_sel),
      .web0  (!d_req.we),
      .wmask0(d_req.be),
      .addr0 (d_word),
      .din0  (d_req.wdata),
      .dout0 (d_dout[b]),
      .csb1  (!i_sel),
      .addr1 (i_word),
      .dout1 (i_dout[b])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rd_q     <= 1'b0;
      d_bank_q   <= '0;
      i_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      i_rd_q     <= 1'b0;
      i_fwd_q    <= 1'b0;
      i_bank_q   <= '0;
      fwd_data_q <= '0;
    end else begin
      d_rvalid_q <= d_gnt;
      d_err_q    <= d_gnt && !d_hit;
      d_rd_q     <= d_gnt && d_hit && !d_req.we;
      d_bank_q   <= d_bank;
      i_rvalid_q <= i_gnt;
      i_err_q    <= i_gnt && !i_hit;
      i_rd_q     <= i_gnt && i_hit && !fwd_ok;
      i_fwd_q    <= i_gnt && fwd_ok;
      i_bank_q   <= i_bank;
      fwd_data_q <= d_req.wdata;
    end
  end

  // Read data is zero unless the response is a successful read, so writes and errors return 0.
  always_comb begin
    d_rdata = '0;
    i_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (d_rd_q && (d_bank_q == BANK_SEL_W'(b))) d_rdata = d_dout[b];
      if (i_rd_q && (i_bank_q == BANK_SEL_W'(b))) i_rdata = i_dout[b];
    end
    if (i_fwd_q) i_rdata = fwd_data_q;
  end

  always_comb begin
    d_rsp = '{gnt: d_gnt, rvalid: d_rvalid_q, rdata: d_rdata, err: d_err_q};
    i_rsp = '{gnt: i_gnt, rvalid: i_rvalid_q, rdata: i_rdata, err: i_err_q};
  end

  assign d_gnt_o          = d_rsp.gnt;
  assign d_rvalid_o       = d_rsp.rvalid;
  assign d_rdata_o        = d_rsp.rdata;
  assign d_err_o          = d_rsp.err;
  assign i_gnt_o          = i_rsp.gnt;
  assign i_rvalid_o       = i_rsp.rvalid;
  assign i_rdata_o        = i_rsp.rdata;
  assign i_err_o          = i_rsp.err;
  assign illegal_memory_o = d_rsp.err || i_rsp.err;

endmodule
